// File: rtl/depth_test_unit.sv
// depth_test_unit: z-buffer depth test between the fragment interpolators and the blend stage
//  Accepts one fragment at a time (x, y, recoded-FN depth), reads the stored depth at
//  y*SCREEN_W+x, compares it with the depth function captured at accept, optionally
//  writes the passing depth back, and presents the passing fragment downstream.
//  Ports:
//   clk, rst (async, active high), en (0 freezes all state)
//   cfg_depth_func, cfg_depth_wr : depth function / write-back enable, sampled at accept
//   frag_valid/frag_ready, frag_x/y/z : fragment input handshake
//   zb_rd_en, zb_wr_en, zb_addr, zb_wr_data, zb_rd_data : z-buffer port, 1-cycle read latency
//   out_valid/out_ready, out_x/y/z : passed fragment handshake
//   pass_cnt : fragments emitted since reset
module depth_test_unit #(
  parameter int EXP_W    = 8,
  parameter int SIG_W    = 24,
  parameter int X_W      = 10,
  parameter int Y_W      = 10,
  parameter int SCREEN_W = 640,
  parameter int ADDR_W   = 19
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [2:0]           cfg_depth_func,
  input  logic                 cfg_depth_wr,
  input  logic                 frag_valid,
  output logic                 frag_ready,
  input  logic [X_W-1:0]       frag_x,
  input  logic [Y_W-1:0]       frag_y,
  input  logic [EXP_W+SIG_W:0] frag_z,
  output logic                 zb_rd_en,
  output logic                 zb_wr_en,
  output logic [ADDR_W-1:0]    zb_addr,
  output logic [EXP_W+SIG_W:0] zb_wr_data,
  input  logic [EXP_W+SIG_W:0] zb_rd_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [X_W-1:0]       out_x,
  output logic [Y_W-1:0]       out_y,
  output logic [EXP_W+SIG_W:0] out_z,
  output logic [31:0]          pass_cnt
);
  localparam int W = EXP_W + SIG_W + 1;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_CMP   = 3'd2;
  localparam logic [2:0] S_DEC   = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_EMIT  = 3'd5;
  logic [2:0]        r_state;
  logic [X_W-1:0]    r_x;
  logic [Y_W-1:0]    r_y;
  logic [W-1:0]      r_z;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_func;
  logic              r_wr;
  logic              r_pass;
  logic [31:0]       r_cnt;
  logic [ADDR_W-1:0] w_addr;
  logic              w_sa, w_sb;
  logic [EXP_W:0]    w_ea, w_eb;
  logic [SIG_W-2:0]  w_ma, w_mb;
  logic              w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_zero_a, w_zero_b;
  logic              w_ordered, w_both_inf, w_both_zero, w_eq_exp, w_lt_mag, w_eq_mag;
  logic              w_olt, w_oeq, w_lt, w_eq, w_gt;
  logic [7:0]        w_func_pass;
  // Address is truncated to ADDR_W; x beyond the row width is the caller's problem.
  assign w_addr = ADDR_W'(frag_y) * ADDR_W'(SCREEN_W) + ADDR_W'(frag_x);
  // Operand a is the fragment depth, b the stored depth.
  assign w_sa = r_z[W-1];
  assign w_ea = r_z[W-2:SIG_W-1];
  assign w_ma = r_z[SIG_W-2:0];
  assign w_sb = zb_rd_data[W-1];
  assign w_eb = zb_rd_data[W-2:SIG_W-1];
  assign w_mb = zb_rd_data[SIG_W-2:0];
  // Recoded exponent top three bits classify the value: 000 zero, 110 infinity, 111 NaN.
  assign w_nan_a  = w_ea[EXP_W -: 3] == 3'b111;
  assign w_nan_b  = w_eb[EXP_W -: 3] == 3'b111;
  assign w_inf_a  = w_ea[EXP_W -: 3] == 3'b110;
  assign w_inf_b  = w_eb[EXP_W -: 3] == 3'b110;
  assign w_zero_a = w_ea[EXP_W -: 3] == 3'b000;
  assign w_zero_b = w_eb[EXP_W -: 3] == 3'b000;
  // Non-special recoded values are magnitude-ordered by {exp, sig} as an unsigned number.
  assign w_ordered   = !w_nan_a && !w_nan_b;
  assign w_both_inf  = w_inf_a && w_inf_b;
  assign w_both_zero = w_zero_a && w_zero_b;
  assign w_eq_exp    = w_ea == w_eb;
  assign w_lt_mag    = (w_ea < w_eb) || (w_eq_exp && (w_ma < w_mb));
  assign w_eq_mag    = w_eq_exp && (w_ma == w_mb);
  assign w_olt = !w_both_zero && ((w_sa && !w_sb) ||
                 (!w_both_inf && ((w_sa && !w_lt_mag && !w_eq_mag) || (!w_sb && w_lt_mag))));
  assign w_oeq = w_both_zero || ((w_sa == w_sb) && (w_both_inf || w_eq_mag));
  assign w_lt  = w_ordered && w_olt;
  assign w_eq  = w_ordered && w_oeq;
  assign w_gt  = w_ordered && !w_olt && !w_oeq;
  // Indexed by depth function code; NaN leaves lt/eq/gt all low, so only NOTEQUAL and ALWAYS pass.
  assign w_func_pass = {1'b1, w_gt | w_eq, ~w_eq, w_gt, w_lt | w_eq, w_eq, w_lt, 1'b0};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_addr  <= '0;
      r_func  <= '0;
      r_wr    <= 1'b0;
      r_pass  <= 1'b0;
      r_cnt   <= '0;
    end else if (en) begin
      case (r_state)
        S_IDLE: if (frag_valid) begin
          r_x     <= frag_x;
          r_y     <= frag_y;
          r_z     <= frag_z;
          r_addr  <= w_addr;
          r_func  <= cfg_depth_func;
          r_wr    <= cfg_depth_wr;
          r_state <= S_READ;
        end
        S_READ:  r_state <= S_CMP;
        S_CMP: begin
          r_pass  <= w_func_pass[r_func];
          r_state <= S_DEC;
        end
        S_DEC:   r_state <= !r_pass ? S_IDLE : r_wr ? S_WRITE : S_EMIT;
        S_WRITE: r_state <= S_EMIT;
        S_EMIT: if (out_ready) begin
          r_cnt   <= r_cnt + 32'd1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign frag_ready = (r_state == S_IDLE) && !rst;
  assign zb_rd_en   = r_state == S_READ;
  assign zb_wr_en   = r_state == S_WRITE;
  assign out_valid  = r_state == S_EMIT;
  assign zb_addr    = r_addr;
  assign zb_wr_data = r_z;
  assign out_x      = r_x;
  assign out_y      = r_y;
  assign out_z      = r_z;
  assign pass_cnt   = r_cnt;
endmodule
